// File: rtl/plr_stage_buf.sv
// plr_stage_buf
// Reusable pipeline-stage register placed between two stages of the core
// pipeline. It carries an opaque DATA_W-bit bundle under a valid/ready
// handshake, supports a synchronous FLUSH and counts stalled cycles.
//
// Build option: define PLR_SKID_EN to add a second (skid) entry. IN_READY then
// depends only on registered state (and RESET), which breaks the
// combinational path from OUT_READY back to IN_READY. Without the macro the
// block is a single register with IN_READY = !out_v || OUT_READY.
//
// Ports
//   CLOCK      in   rising-edge clock
//   RESET      in   synchronous, active-high reset
//   FLUSH      in   synchronous kill of all held entries (counter kept)
//   IN_VALID   in   upstream offers IN_DATA
//   IN_READY   out  block accepts a bundle this cycle (0 while RESET)
//   IN_DATA    in   upstream bundle, DATA_W bits
//   OUT_VALID  out  OUT_DATA holds a live bundle
//   OUT_READY  in   downstream consumes OUT_DATA this cycle
//   OUT_DATA   out  bundle presented downstream, DATA_W bits
//   STALL_CNT  out  saturating count of OUT_VALID && !OUT_READY edges
module plr_stage_buf #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [CNT_W-1:0]  STALL_CNT
);

  // Increment that sticks at the all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  logic              out_v_q, out_v_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              in_xfer;
  logic              stall;

`ifdef PLR_SKID_EN
  logic              sk_v_q, sk_v_d;
  logic [DATA_W-1:0] sk_data_q, sk_data_d;

  // Ready depends only on the skid occupancy: one free slot is always
  // enough to absorb the bundle that arrives while downstream stalls.
  assign IN_READY = !RESET && !sk_v_q;
`else
  assign IN_READY = !RESET && (!out_v_q || OUT_READY);
`endif

  assign in_xfer = IN_VALID && IN_READY;
  assign stall   = out_v_q && !OUT_READY;

  always_comb begin
    out_v_d     = out_v_q;
    out_data_d  = out_data_q;
`ifdef PLR_SKID_EN
    sk_v_d      = sk_v_q;
    sk_data_d   = sk_data_q;
    if (!out_v_q || OUT_READY) begin
      if (sk_v_q) begin
        // Older bundle in the skid moves forward first to keep order.
        out_v_d    = 1'b1;
        out_data_d = sk_data_q;
        sk_v_d     = in_xfer;
        if (in_xfer) sk_data_d = IN_DATA;
      end else begin
        out_v_d = in_xfer;
        if (in_xfer) out_data_d = IN_DATA;
      end
    end else if (in_xfer) begin
      sk_v_d    = 1'b1;
      sk_data_d = IN_DATA;
    end
`else
    if (!out_v_q || OUT_READY) begin
      out_v_d = in_xfer;
      if (in_xfer) out_data_d = IN_DATA;
    end
`endif
    // Flush drops held entries and any bundle accepted on the same edge.
    if (FLUSH) begin
      out_v_d    = 1'b0;
      out_data_d = '0;
`ifdef PLR_SKID_EN
      sk_v_d     = 1'b0;
`endif
    end
    stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      out_v_q     <= 1'b0;
      out_data_q  <= '0;
      stall_cnt_q <= '0;
`ifdef PLR_SKID_EN
      sk_v_q      <= 1'b0;
      sk_data_q   <= '0;
`endif
    end else begin
      out_v_q     <= out_v_d;
      out_data_q  <= out_data_d;
      stall_cnt_q <= stall_cnt_d;
`ifdef PLR_SKID_EN
      sk_v_q      <= sk_v_d;
      sk_data_q   <= sk_data_d;
`endif
    end
  end

  assign OUT_VALID = out_v_q;
  assign OUT_DATA  = out_data_q;
  assign STALL_CNT = stall_cnt_q;

endmodule

// File: tb/tb_plr_stage_buf.sv
// Directed bench for plr_stage_buf: a vector table (stream, flush, stall
// counter saturation, reset mid-stream), hand-written skid/flush sequences
// and a random handshake run checked against an in-order queue.
// The DUT is built with CNT_W=3 so that counter saturation is reachable.
module tb_plr_stage_buf;

`ifdef PLR_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  stall_cnt;

  int checks;
  int failures;

  plr_stage_buf #(.DATA_W(32), .CNT_W(3)) dut (
    .CLOCK    (clk),
    .RESET    (rst),
    .FLUSH    (flush),
    .IN_VALID (in_valid),
    .IN_READY (in_ready),
    .IN_DATA  (in_data),
    .OUT_VALID(out_valid),
    .OUT_READY(out_ready),
    .OUT_DATA (out_data),
    .STALL_CNT(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        rdy_ns;   // expected IN_READY before the edge, single register
    logic        rdy_sk;   // expected IN_READY before the edge, skid build
    logic        ov;       // expected OUT_VALID after the edge
    logic [31:0] od;       // expected OUT_DATA after the edge
    logic [2:0]  cnt;      // expected STALL_CNT after the edge
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic f, logic iv, logic [31:0] d, logic o,
                              logic rn, logic rs, logic ov, logic [31:0] od,
                              logic [2:0] c);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.d = d; v.ordy = o;
    v.rdy_ns = rn; v.rdy_sk = rs; v.ov = ov; v.od = od; v.cnt = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [31:0] d, input logic o);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = o;
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] q[$];
  logic [31:0] exp_d;

  initial begin
    checks = 0;
    failures = 0;
    drive(1, 0, 0, 0, 0);

    // ---------------- vector table ----------------
    tbl.push_back(mk(1,0,0,32'h0 ,0, 0,0, 0,32'h0 ,0));
    tbl.push_back(mk(1,0,1,32'h55,1, 0,0, 0,32'h0 ,0));
    for (int k = 1; k <= 16; k++)
      tbl.push_back(mk(0,0,1,k,1, 1,1, 1,k,0));
    tbl.push_back(mk(0,0,0,32'h0 ,1, 1,1, 0,32'h10,0));
    tbl.push_back(mk(0,0,1,32'hA ,0, 1,1, 1,32'hA ,0));
    tbl.push_back(mk(0,0,0,32'h0 ,0, 0,1, 1,32'hA ,1));
    tbl.push_back(mk(0,0,0,32'h0 ,0, 0,1, 1,32'hA ,2));
    tbl.push_back(mk(0,1,0,32'h0 ,0, 0,1, 0,32'h0 ,3));
    tbl.push_back(mk(0,1,1,32'hC ,1, 1,1, 0,32'h0 ,3));
    tbl.push_back(mk(0,0,1,32'h77,1, 1,1, 1,32'h77,3));
    tbl.push_back(mk(0,0,0,32'h0 ,0, 0,1, 1,32'h77,4));
    tbl.push_back(mk(0,0,0,32'h0 ,0, 0,1, 1,32'h77,5));
    tbl.push_back(mk(0,0,0,32'h0 ,0, 0,1, 1,32'h77,6));
    tbl.push_back(mk(0,0,0,32'h0 ,0, 0,1, 1,32'h77,7));
    tbl.push_back(mk(0,0,0,32'h0 ,0, 0,1, 1,32'h77,7));
    tbl.push_back(mk(0,0,0,32'h0 ,0, 0,1, 1,32'h77,7));
    tbl.push_back(mk(0,1,0,32'h0 ,0, 0,1, 0,32'h0 ,7));
    tbl.push_back(mk(0,0,1,32'h21,1, 1,1, 1,32'h21,7));
    tbl.push_back(mk(1,0,1,32'h22,0, 0,0, 0,32'h0 ,0));
    tbl.push_back(mk(0,0,1,32'h23,1, 1,1, 1,32'h23,0));
    tbl.push_back(mk(0,0,0,32'h0 ,1, 1,1, 0,32'h23,0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      #1;
      chk($sformatf("tbl%0d_in_ready", i), in_ready, SKID ? tbl[i].rdy_sk : tbl[i].rdy_ns);
      cyc();
      chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].od);
      chk($sformatf("tbl%0d_stall_cnt", i), stall_cnt, tbl[i].cnt);
    end

    // ---------------- stall with second bundle pushed ----------------
    drive(0, 0, 1, 32'hA, 0); cyc();                 // 0xA into out
    drive(0, 0, 0, 32'h0, 0); cyc();                 // one stall, cnt=1
    drive(0, 0, 1, 32'hB, 0); #1;
    chk("push_b_in_ready", in_ready, SKID ? 1 : 0);
    cyc();                                           // cnt=2
    drive(0, 0, 0, 32'h0, 0); #1;
    chk("full_in_ready", in_ready, 0);
    chk("full_out_data", out_data, 32'hA);
    drive(0, 0, 0, 32'h0, 1); #1;
    chk("drain1_out_valid", out_valid, 1);
    chk("drain1_in_ready", in_ready, SKID ? 0 : 1);
    cyc();
    chk("drain1_after_valid", out_valid, SKID ? 1 : 0);
    chk("drain1_after_data", out_data, SKID ? 32'hB : 32'hA);
    chk("drain1_in_ready_back", in_ready, 1);
    cyc();
    chk("drain2_out_valid", out_valid, 0);
    chk("drain2_out_data", out_data, SKID ? 32'hB : 32'hA);
    chk("drain_stall_cnt", stall_cnt, 2);

    // ---------------- flush with both entries held ----------------
    drive(0, 0, 1, 32'hA, 0); cyc();                 // 0xA into out
    drive(0, 0, 1, 32'hB, 0); cyc();                 // 0xB into skid (if built), cnt=3
    drive(0, 1, 1, 32'hC, 0); #1;
    chk("flush_in_ready", in_ready, 0);
    cyc();                                           // cnt=4
    drive(0, 0, 0, 32'h0, 1); #1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_data", out_data, 32'h0);
    chk("flush_in_ready_after", in_ready, 1);
    cyc();
    chk("flush_no_skid_leak_valid", out_valid, 0);
    chk("flush_no_skid_leak_data", out_data, 32'h0);
    chk("flush_stall_cnt", stall_cnt, 4);

    // ---------------- random handshake against an order queue ----------------
    drive(1, 0, 0, 32'h0, 0); cyc();
    for (int c = 0; c < 10000 + 8; c++) begin
      if (c < 10000)
        drive(0, 0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      else
        drive(0, 0, 0, 32'h0, 1);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rand_unexpected_out actual=%0h required=none", out_data);
        end else begin
          exp_d = q.pop_front();
          chk("rand_order", out_data, exp_d);
        end
      end
      if (in_valid && in_ready) q.push_back(in_data);
      cyc();
    end
    chk("rand_queue_empty", q.size(), 0);
    chk("rand_final_out_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
